vin_pattern_gen: RTL and testbench

//   Parametrised internal video source: generates vsync/hsync/pclk/de/pixel timing
//   and a selectable test pattern. Feeds the video-input path in place of an external source.

---
 rtl/vin_pkg.sv | 39 +++
 rtl/vin_timing.sv | 80 ++++++++
 rtl/vin_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_vin_pattern_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vin_pkg.sv
// Shared definitions for the internal video source: pattern modes, run states,
// default timing constants and counter sizing helpers.
package vin_pkg;

   typedef enum logic [1:0] {
      VIN_MODE_SOLID  = 2'd0,
      VIN_MODE_HRAMP  = 2'd1,
      VIN_MODE_CHECK  = 2'd2,
      VIN_MODE_SCROLL = 2'd3
   } vin_mode_e;

   typedef enum logic [1:0] {
      VIN_ST_IDLE  = 2'd0,
      VIN_ST_RUN   = 2'd1,
      VIN_ST_DRAIN = 2'd2
   } vin_state_e;

   localparam int VIN_H_ACTIVE = 1600;
   localparam int VIN_H_FP     = 24;
   localparam int VIN_H_SYNC   = 16;
   localparam int VIN_H_BP     = 40;
   localparam int VIN_V_ACTIVE = 1200;
   localparam int VIN_V_FP     = 3;
   localparam int VIN_V_SYNC   = 2;
   localparam int VIN_V_BP     = 10;
   localparam int VIN_PIX_W    = 8;
   localparam int VIN_PCLK_DIV = 2;
   localparam int VIN_CHK_LOG2 = 3;

   function automatic int vin_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Bits needed to hold 0..count-1, never less than one.
   function automatic int vin_cnt_w(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/vin_timing.sv
// Pixel divider and h/v raster counters with combinational decode of de, syncs,
// pixel tick, frame boundaries and the next pixel-clock level.
module vin_timing
   import vin_pkg::*;
#(
   parameter int H_ACTIVE  = VIN_H_ACTIVE,
   parameter int H_FP      = VIN_H_FP,
   parameter int H_SYNC    = VIN_H_SYNC,
   parameter int H_BP      = VIN_H_BP,
   parameter int V_ACTIVE  = VIN_V_ACTIVE,
   parameter int V_FP      = VIN_V_FP,
   parameter int V_SYNC    = VIN_V_SYNC,
   parameter int V_BP      = VIN_V_BP,
   parameter int PCLK_DIV  = VIN_PCLK_DIV,
   localparam int H_TOTAL  = vin_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = vin_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int HW       = vin_cnt_w(H_TOTAL),
   localparam int VW       = vin_cnt_w(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   output logic          tick,
   output logic          period_end,
   output logic          frame_first,
   output logic          frame_last,
   output logic          de,
   output logic          hs_act,
   output logic          vs_act,
   output logic          pclk_next,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v
);

   localparam int DW = vin_cnt_w(PCLK_DIV);

   logic [DW-1:0] div;
   logic [DW-1:0] div_nxt;
   logic          h_last;
   logic          v_last;

   always_comb begin
      div_nxt     = (32'(div) == PCLK_DIV - 1) ? '0 : div + 1'b1;
      h_last      = (32'(h) == H_TOTAL - 1);
      v_last      = (32'(v) == V_TOTAL - 1);
      tick        = run && (div == '0);
      period_end  = run && (32'(div) == PCLK_DIV - 1);
      frame_first = (h == '0) && (v == '0);
      frame_last  = h_last && v_last;
      de          = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
      hs_act      = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
      vs_act      = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
      // Low for the first half of each pixel period, high for the second half.
      pclk_next   = run && ((div_nxt == '0) || (32'(div_nxt) > PCLK_DIV / 2));
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else if (!run) begin
         div <= '0;
         h   <= '0;
         v   <= '0;
      end else begin
         div <= div_nxt;
         if (tick) begin
            if (h_last) begin
               h <= '0;
               v <= v_last ? '0 : v + 1'b1;
            end else begin
               h <= h + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/vin_pattern_gen.sv
// Internal video source: run/stop control, test-pattern mux and registered video outputs.
// Define VIN_PATGEN_BORDER_EN to force a one-pixel all-ones border around the active area.
module vin_pattern_gen
   import vin_pkg::*;
#(
   parameter int H_ACTIVE = VIN_H_ACTIVE,
   parameter int H_FP     = VIN_H_FP,
   parameter int H_SYNC   = VIN_H_SYNC,
   parameter int H_BP     = VIN_H_BP,
   parameter int V_ACTIVE = VIN_V_ACTIVE,
   parameter int V_FP     = VIN_V_FP,
   parameter int V_SYNC   = VIN_V_SYNC,
   parameter int V_BP     = VIN_V_BP,
   parameter int PIX_W    = VIN_PIX_W,
   parameter int PCLK_DIV = VIN_PCLK_DIV,
   parameter int HS_POL   = 1,
   parameter int VS_POL   = 1,
   parameter int CHK_LOG2 = VIN_CHK_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] fill,
   output logic             v_vsync,
   output logic             v_hsync,
   output logic             v_pclk,
   output logic             v_de,
   output logic [PIX_W-1:0] v_pixel,
   output logic             frame_start
);

   localparam int   HW      = vin_cnt_w(vin_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int   VW      = vin_cnt_w(vin_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam logic HS_IDLE = (HS_POL == 0);
   localparam logic VS_IDLE = (VS_POL == 0);

   vin_state_e       state;
   vin_mode_e        cur_mode;
   vin_mode_e        eff_mode;
   logic [PIX_W-1:0] cur_fill;
   logic [PIX_W-1:0] eff_fill;
   logic [7:0]       fcnt;
   logic [7:0]       scroll;
   logic [7:0]       eff_scroll;
   logic [PIX_W-1:0] pat;
   logic [PIX_W-1:0] pix_next;

   logic          run;
   logic          tick;
   logic          period_end;
   logic          frame_first;
   logic          frame_last;
   logic          de;
   logic          hs_act;
   logic          vs_act;
   logic          pclk_next;
   logic [HW-1:0] h;
   logic [VW-1:0] v;

   assign run = (state != VIN_ST_IDLE);

   vin_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .PCLK_DIV (PCLK_DIV)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .tick        (tick),
      .period_end  (period_end),
      .frame_first (frame_first),
      .frame_last  (frame_last),
      .de          (de),
      .hs_act      (hs_act),
      .vs_act      (vs_act),
      .pclk_next   (pclk_next),
      .h           (h),
      .v           (v)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      eff_mode   = cur_mode;
      eff_fill   = cur_fill;
      eff_scroll = scroll;
      pat        = '0;
      // The first pixel of a frame must already use the freshly sampled controls.
      if (frame_first) begin
         eff_mode   = vin_mode_e'(mode);
         eff_fill   = fill;
         eff_scroll = fcnt;
      end
      case (eff_mode)
         VIN_MODE_SOLID:  pat = eff_fill;
         VIN_MODE_HRAMP:  pat = PIX_W'(32'(h));
         VIN_MODE_CHECK:  pat = ((((32'(h) ^ 32'(v)) >> CHK_LOG2) & 32'd1) != 32'd0) ? '1 : '0;
         VIN_MODE_SCROLL: pat = PIX_W'(32'(h) + 32'(eff_scroll));
         default:         pat = '0;
      endcase
`ifdef VIN_PATGEN_BORDER_EN
      if ((h == '0) || (32'(h) == H_ACTIVE - 1) || (v == '0) || (32'(v) == V_ACTIVE - 1))
         pix_next = de ? '1 : '0;
      else
         pix_next = de ? pat : '0;
`else
      pix_next = de ? pat : '0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= VIN_ST_IDLE;
         cur_mode    <= VIN_MODE_SOLID;
         cur_fill    <= '0;
         fcnt        <= '0;
         scroll      <= '0;
         v_pclk      <= 1'b0;
         v_de        <= 1'b0;
         v_pixel     <= '0;
         v_hsync     <= HS_IDLE;
         v_vsync     <= VS_IDLE;
         frame_start <= 1'b0;
      end else begin
         v_pclk      <= pclk_next;
         frame_start <= 1'b0;
         case (state)
            VIN_ST_IDLE: begin
               v_de    <= 1'b0;
               v_pixel <= '0;
               v_hsync <= HS_IDLE;
               v_vsync <= VS_IDLE;
               if (en) state <= VIN_ST_RUN;
            end
            VIN_ST_RUN: begin
               if (tick) begin
                  v_de        <= de;
                  v_pixel     <= pix_next;
                  v_hsync     <= hs_act ? ~HS_IDLE : HS_IDLE;
                  v_vsync     <= vs_act ? ~VS_IDLE : VS_IDLE;
                  frame_start <= frame_first;
                  if (frame_first) begin
                     cur_mode <= eff_mode;
                     cur_fill <= eff_fill;
                     scroll   <= fcnt;
                     fcnt     <= fcnt + 8'd1;
                  end
                  if (frame_last && !en) state <= VIN_ST_DRAIN;
               end
            end
            // Let the final pixel period finish so its pclk rise still happens.
            VIN_ST_DRAIN: begin
               if (period_end) state <= VIN_ST_IDLE;
            end
            default: state <= VIN_ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// Scoreboard bench for vin_pattern_gen: stimulus pushes whole expected frames from a
// raster-level model, a pclk-rise monitor pops and compares every pixel period.
module tb_vin_pattern_gen;

   localparam int HA = 8, HF = 1, HSN = 2, HB = 1;
   localparam int VA = 4, VF = 1, VSN = 1, VB = 1;
   localparam int PW = 8, PD = 2, HP = 1, VP = 0, CK = 1;
   localparam int HT = HA + HF + HSN + HB;
   localparam int VT = VA + VF + VSN + VB;
   localparam int FRAME_CLK = HT * VT * PD;
   localparam logic HS_IDLE = (HP == 0);
   localparam logic VS_IDLE = (VP == 0);

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic [PW-1:0] fill;
   logic          v_vsync, v_hsync, v_pclk, v_de, frame_start;
   logic [PW-1:0] v_pixel;

   vin_pattern_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSN), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSN), .V_BP (VB),
      .PIX_W (PW), .PCLK_DIV (PD), .HS_POL (HP), .VS_POL (VP), .CHK_LOG2 (CK)
   ) dut (
      .clk (clk), .rst (rst), .en (en), .mode (mode), .fill (fill),
      .v_vsync (v_vsync), .v_hsync (v_hsync), .v_pclk (v_pclk), .v_de (v_de),
      .v_pixel (v_pixel), .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] tup;
      int          frame;
      int          x;
      int          y;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_fcnt   = 0;
   int   fs_total = 0;
   int   mon_last = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [PW-1:0] ref_pix(input int x, input int y, input int md,
                                             input int fl, input int n);
      int val;
      case (md)
         0:       val = fl;
         1:       val = x;
         2:       val = (((x >> CK) ^ (y >> CK)) & 1) != 0 ? (1 << PW) - 1 : 0;
         default: val = x + (n % 256);
      endcase
`ifdef VIN_PATGEN_BORDER_EN
      if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) val = (1 << PW) - 1;
`endif
      return val[PW-1:0];
   endfunction

   // Expected output of one complete frame, in raster order, numbered from reset.
   task automatic push_frame(input int md, input int fl);
      exp_t    e;
      logic    fs_b, de_b, hs_b, vs_b;
      logic [PW-1:0] pix;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            fs_b = (x == 0 && y == 0);
            de_b = (x < HA && y < VA);
            hs_b = (x >= HA + HF && x < HA + HF + HSN) ? ~HS_IDLE : HS_IDLE;
            vs_b = (y >= VA + VF && y < VA + VF + VSN) ? ~VS_IDLE : VS_IDLE;
            pix  = de_b ? ref_pix(x, y, md, fl, m_fcnt) : '0;
            e.tup   = 32'({fs_b, de_b, hs_b, vs_b, pix});
            e.frame = m_fcnt;
            e.x     = x;
            e.y     = y;
            exp_q.push_back(e);
         end
      end
      m_fcnt++;
   endtask

   always @(negedge clk) if (rst === 1'b1 && frame_start === 1'b1) fs_total++;

   always @(posedge v_pclk) begin
      exp_t e;
      logic fs;
      fs       = (fs_total != mon_last);
      mon_last = fs_total;
      if (exp_q.size() == 0) begin
         check("unexpected pclk rise", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("pixel f%0d x%0d y%0d {fs,de,hs,vs,pix}", e.frame, e.x, e.y),
               32'({fs, v_de, v_hsync, v_vsync, v_pixel}), e.tup);
      end
   end

   task automatic wait_fs(input string tag);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (frame_start !== 1'b1 && c < 2 * FRAME_CLK + 50);
      if (frame_start !== 1'b1) check({"frame_start timeout ", tag}, 32'd0, 32'd1);
   endtask

   task automatic drain_and_idle(input string tag);
      int c = 0;
      int bad = 0;
      int fs0;
      while (exp_q.size() != 0 && c < 2 * FRAME_CLK + 50) begin
         @(negedge clk);
         c++;
      end
      check({"frame completed before stop ", tag}, 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      fs0 = fs_total;
      repeat (2 * FRAME_CLK) begin
         @(negedge clk);
         if (v_de !== 1'b0 || v_pclk !== 1'b0 || v_pixel !== '0) bad++;
      end
      check({"idle outputs ", tag}, 32'(bad), 32'd0);
      check({"idle frame_start ", tag}, 32'(fs_total - fs0), 32'd0);
   endtask

   initial begin
      int d, md, fl, cnt, bad;
      rst  = 1'b0;
      en   = 1'b0;
      mode = 2'd0;
      fill = '0;
      repeat (3) @(negedge clk);
      check("reset {de,pclk,hs,vs,fs,pix}",
            32'({v_de, v_pclk, v_hsync, v_vsync, frame_start, v_pixel}),
            32'({1'b0, 1'b0, HS_IDLE, VS_IDLE, 1'b0, {PW{1'b0}}}));
      rst = 1'b1;

      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (v_de !== 1'b0 || v_pclk !== 1'b0 || v_hsync !== HS_IDLE || v_vsync !== VS_IDLE) bad++;
      end
      check("en=0 outputs idle", 32'(bad), 32'd0);
      check("en=0 no frame_start", 32'(fs_total), 32'd0);

      mode = 2'd1;
      fill = PW'($urandom);
      push_frame(1, int'(fill));
      en = 1'b1;
      wait_fs("first frame");
      // Changed during frame 0; takes effect on frame 1.
      mode = 2'd2;
      fill = PW'($urandom);
      push_frame(2, int'(fill));
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (frame_start !== 1'b1 && cnt < 1000);
      check("frame_start period in clk", 32'(cnt), 32'(FRAME_CLK));

      for (int i = 0; i < 258; i++) begin
         d = $urandom_range(1, FRAME_CLK - 20);
         repeat (d) @(negedge clk);
         if (i < 4) md = i;
         else if (i >= 248) md = 3;
         else md = $urandom_range(0, 3);
         fl = (i == 0) ? 32'h40 : int'($urandom_range(0, (1 << PW) - 1));
         mode = md[1:0];
         fill = fl[PW-1:0];
         if (i == 7) begin
            en = 1'b0;
            repeat (3) @(negedge clk);
            en = 1'b1;
         end
         push_frame(md, fl);
         wait_fs($sformatf("loop %0d", i));
      end

      repeat ($urandom_range(1, FRAME_CLK - 20)) @(negedge clk);
      en = 1'b0;
      drain_and_idle("after loop");

      mode = 2'd3;
      fill = PW'($urandom);
      push_frame(3, int'(fill));
      en = 1'b1;
      wait_fs("restart");
      repeat ($urandom_range(30, 60)) @(negedge clk);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async reset {de,pclk,hs,vs,fs,pix}",
            32'({v_de, v_pclk, v_hsync, v_vsync, frame_start, v_pixel}),
            32'({1'b0, 1'b0, HS_IDLE, VS_IDLE, 1'b0, {PW{1'b0}}}));
      exp_q.delete();
      m_fcnt = 0;
      @(negedge clk);
      mode = 2'd3;
      push_frame(3, int'(fill));
      rst = 1'b1;
      wait_fs("after reset");
      repeat (50) @(negedge clk);
      en = 1'b0;
      drain_and_idle("after reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
